// File: rtl/i2c_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_pkg
// Purpose  : Shared types and defaults for the I2C slave transmit path.
//            Holds the byte-shifter state encoding and the default byte width.
// Ports    : (package - none)
// Revision : 1.0  initial release
// ============================================================================
package i2c_slave_pkg;

  localparam int BYTE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } tx_state_t;

endpackage : i2c_slave_pkg
`default_nettype wire

// File: rtl/scl_edge.sv
`default_nettype none
// ============================================================================
// Module   : scl_edge
// Purpose  : Brings the raw bus SCL into the clk domain through two flops and
//            detects edges against a one-flop history.
// Ports    : clk      - system clock
//            n_rst    - asynchronous active-low reset
//            scl_in   - raw SCL, asynchronous to clk
//            scl_rise - high for one cycle after a synchronized rising edge
//            scl_fall - high for one cycle after a synchronized falling edge
// Revision : 1.0  initial release
// ============================================================================
module scl_edge (
  input  logic clk,
  input  logic n_rst,
  input  logic scl_in,
  output logic scl_rise,
  output logic scl_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  // All three flops reset high to match an idle bus, so releasing reset
  // while SCL is high cannot manufacture an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= scl_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign scl_fall = ~r_sync2 &  r_hist;
  assign scl_rise =  r_sync2 & ~r_hist;

endmodule : scl_edge
`default_nettype wire

// File: rtl/tx_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tx_byte_shifter
// Purpose  : Serializes bytes MSB first onto the SDA output select, advancing
//            one bit per SCL falling edge while the controller is in its
//            transmit phase. A one-entry hold register lets the next byte be
//            queued so back-to-back bytes run without returning to IDLE.
// Ports    : clk          - system clock
//            n_rst        - asynchronous active-low reset
//            scl_in       - raw SCL, asynchronous to clk
//            tx_enable    - transmit phase; SCL falls only count while high
//            load_data    - single-cycle strobe offering tx_data
//            tx_data      - byte to transmit, MSB first
//            tx_abort     - synchronous flush of all transmit state
//            tx_out       - current bit (shift register MSB)
//            byte_sent    - one-cycle pulse on byte completion
//            busy         - high in SHIFT and DONE
//            load_overrun - one-cycle pulse when an offered byte is dropped
//            bit_count    - bits shifted in the current byte
// Revision : 1.0  initial release
// ============================================================================
module tx_byte_shifter
  import i2c_slave_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              scl_in,
  input  logic              tx_enable,
  input  logic              load_data,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_abort,
  output logic              tx_out,
  output logic              byte_sent,
  output logic              busy,
  output logic              load_overrun,
  output logic [3:0]        bit_count
);

  localparam logic [3:0] c_LAST_IDX = 4'(BYTE_W - 1);

  tx_state_t         r_state;
  logic [BYTE_W-1:0] r_shreg;
  logic [BYTE_W-1:0] r_hold;
  logic              r_hold_valid;
  logic [3:0]        r_bit_count;
  logic              r_byte_sent;
  logic              r_busy;
  logic              r_load_overrun;
  logic              w_scl_fall;
  logic              w_scl_rise_unused;

  scl_edge u_scl_edge (
    .clk      (clk),
    .n_rst    (n_rst),
    .scl_in   (scl_in),
    .scl_rise (w_scl_rise_unused),
    .scl_fall (w_scl_fall)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= ST_IDLE;
      r_shreg        <= '1;
      r_hold         <= '0;
      r_hold_valid   <= 1'b0;
      r_bit_count    <= 4'd0;
      r_byte_sent    <= 1'b0;
      r_busy         <= 1'b0;
      r_load_overrun <= 1'b0;
    end else begin
      r_byte_sent    <= 1'b0;
      r_load_overrun <= 1'b0;
      if (tx_abort) begin
        // Abort overrides any load or shift requested in the same cycle.
        r_state      <= ST_IDLE;
        r_shreg      <= '1;
        r_hold_valid <= 1'b0;
        r_bit_count  <= 4'd0;
        r_busy       <= 1'b0;
      end else begin
        // A full hold register drops the offered byte in every state,
        // including DONE where the hold is being drained this same cycle.
        if (load_data && r_hold_valid) begin
          r_load_overrun <= 1'b1;
        end
        case (r_state)
          ST_IDLE: begin
            if (load_data) begin
              r_shreg     <= tx_data;
              r_bit_count <= 4'd0;
              r_state     <= ST_SHIFT;
              r_busy      <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (load_data && !r_hold_valid) begin
              r_hold       <= tx_data;
              r_hold_valid <= 1'b1;
            end
            if (tx_enable && w_scl_fall) begin
              // Fill with ones so the line idles high once the byte is out.
              r_shreg     <= {r_shreg[BYTE_W-2:0], 1'b1};
              r_bit_count <= r_bit_count + 4'd1;
              if (r_bit_count == c_LAST_IDX) begin
                r_state     <= ST_DONE;
                r_byte_sent <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (r_hold_valid) begin
              r_shreg      <= r_hold;
              r_hold_valid <= 1'b0;
              r_bit_count  <= 4'd0;
              r_state      <= ST_SHIFT;
            end else if (load_data) begin
              r_shreg     <= tx_data;
              r_bit_count <= 4'd0;
              r_state     <= ST_SHIFT;
            end else begin
              r_shreg <= '1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_shreg <= '1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_out       = r_shreg[BYTE_W-1];
  assign byte_sent    = r_byte_sent;
  assign busy         = r_busy;
  assign load_overrun = r_load_overrun;
  assign bit_count    = r_bit_count;

endmodule : tx_byte_shifter
`default_nettype wire

// File: tb/tb_tx_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_byte_shifter
// Purpose  : Self-checking bench for tx_byte_shifter. Expected bits are queued
//            MSB first when a byte is accepted and popped ahead of each SCL
//            fall; pulse counters are compared against expected totals.
// Revision : 1.0  initial release
// ============================================================================
module tb_tx_byte_shifter;

  localparam int W = 8;

  logic         clk       = 1'b0;
  logic         n_rst     = 1'b1;
  logic         scl_in    = 1'b1;
  logic         tx_enable = 1'b0;
  logic         load_data = 1'b0;
  logic [W-1:0] tx_data   = '0;
  logic         tx_abort  = 1'b0;
  logic         tx_out;
  logic         byte_sent;
  logic         busy;
  logic         load_overrun;
  logic [3:0]   bit_count;

  int n_checks   = 0;
  int n_errors   = 0;
  bit exp_q[$];
  int sent_cnt   = 0;
  int ovr_cnt    = 0;
  int exp_sent   = 0;
  int exp_ovr    = 0;
  bit watch_busy = 1'b0;
  int busy_low   = 0;

  tx_byte_shifter #(.BYTE_W(W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .scl_in       (scl_in),
    .tx_enable    (tx_enable),
    .load_data    (load_data),
    .tx_data      (tx_data),
    .tx_abort     (tx_abort),
    .tx_out       (tx_out),
    .byte_sent    (byte_sent),
    .busy         (busy),
    .load_overrun (load_overrun),
    .bit_count    (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Pulse counters and the IDLE-implies-high check, sampled on the falling edge.
  always @(negedge clk) begin
    if (n_rst) begin
      if (byte_sent)    sent_cnt++;
      if (load_overrun) ovr_cnt++;
      if (watch_busy && !busy) busy_low++;
      if (!busy) check_val("idle_tx_high", tx_out, 1);
    end
  end

  task automatic load_byte(input logic [W-1:0] v, input bit accepted);
    @(negedge clk);
    load_data = 1'b1;
    tx_data   = v;
    @(negedge clk);
    load_data = 1'b0;
    if (accepted) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(v[i]);
    end else begin
      exp_ovr++;
    end
  endtask

  task automatic fall_once();
    @(negedge clk);
    scl_in = 1'b0;
    repeat (4) @(negedge clk);
    scl_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_checked(input int n);
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        check_val("queue_underrun", 1, 0);
      end else begin
        check_val("tx_bit", tx_out, exp_q.pop_front());
      end
      fall_once();
    end
  endtask

  initial begin
    // Reset and its immediate output values.
    #1 n_rst = 1'b0;
    #1;
    check_val("rst_tx_out", tx_out, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_bit_count", bit_count, 0);
    check_val("rst_byte_sent", byte_sent, 0);
    check_val("rst_overrun", load_overrun, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("post_rst_busy", busy, 0);

    // Single byte A5.
    tx_enable = 1'b1;
    load_byte(8'hA5, 1'b1);
    check_val("a5_busy", busy, 1);
    shift_checked(8);
    exp_sent++;
    check_val("a5_idle_busy", busy, 0);
    check_val("a5_idle_tx", tx_out, 1);
    check_val("a5_sent", sent_cnt, exp_sent);

    // Back-to-back 3C then held C3.
    load_byte(8'h3C, 1'b1);
    load_byte(8'hC3, 1'b1);
    watch_busy = 1'b1;
    shift_checked(15);
    watch_busy = 1'b0;
    shift_checked(1);
    exp_sent += 2;
    check_val("b2b_no_idle", busy_low, 0);
    check_val("b2b_sent", sent_cnt, exp_sent);
    check_val("b2b_idle_busy", busy, 0);

    // Overrun: FF shifting, 00 held, 55 dropped.
    load_byte(8'hFF, 1'b1);
    load_byte(8'h00, 1'b1);
    load_byte(8'h55, 1'b0);
    @(negedge clk);
    check_val("ovr_pulses", ovr_cnt, exp_ovr);
    shift_checked(16);
    exp_sent += 2;
    check_val("ovr_sent", sent_cnt, exp_sent);
    check_val("ovr_q_empty", exp_q.size(), 0);

    // tx_enable low ignores SCL falls.
    tx_enable = 1'b0;
    load_byte(8'h80, 1'b1);
    repeat (4) fall_once();
    check_val("dis_bit_count", bit_count, 0);
    check_val("dis_tx_out", tx_out, 1);
    tx_enable = 1'b1;
    shift_checked(8);
    exp_sent++;
    check_val("dis_sent", sent_cnt, exp_sent);

    // Abort after 3 bits, colliding with a load.
    load_byte(8'h0F, 1'b1);
    shift_checked(3);
    check_val("abort_pre_count", bit_count, 3);
    @(negedge clk);
    tx_abort  = 1'b1;
    load_data = 1'b1;
    tx_data   = 8'hAA;
    @(negedge clk);
    tx_abort  = 1'b0;
    load_data = 1'b0;
    exp_q.delete();
    check_val("abort_tx_out", tx_out, 1);
    check_val("abort_busy", busy, 0);
    check_val("abort_bit_count", bit_count, 0);
    repeat (3) @(negedge clk);
    check_val("abort_busy_hold", busy, 0);
    check_val("abort_no_sent", sent_cnt, exp_sent);

    // Asynchronous reset mid-byte with a byte held.
    load_byte(8'h4B, 1'b1);
    load_byte(8'hE1, 1'b1);
    shift_checked(5);
    check_val("mid_bit_count", bit_count, 5);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check_val("arst_tx_out", tx_out, 1);
    check_val("arst_busy", busy, 0);
    check_val("arst_bit_count", bit_count, 0);
    check_val("arst_byte_sent", byte_sent, 0);
    check_val("arst_overrun", load_overrun, 0);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) fall_once();
    check_val("arst_stay_idle", busy, 0);
    check_val("arst_no_sent", sent_cnt, exp_sent);
    check_val("final_overrun", ovr_cnt, exp_ovr);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tx_byte_shifter
`default_nettype wire
